rx_mac_interface: RTL

Receive-side counterpart of the TX MAC interface. Takes 64-bit frames from the 10G MAC receive client and writes each into the internal 512-qword frame buffer as one header qword followed by the payload qwords. Frames are committed to the downstream reader only after the MAC reports good status. Bad or overflowing frames are rolled back so they are never visible. The buffer holds the same layout the TX side consumes: header `[63:32]` is the frame byte count and `[31:0]` is zero.

---
 rtl/rx_mac_interface_pkg.sv | 25 ++
 rtl/byte_mask_popcount.sv | 22 ++
 rtl/rx_mac_interface.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rx_mac_interface_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_mac_interface_pkg
//  Description : Shared definitions for the RX MAC interface: FSM state
//                encodings, frame header field positions, default geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package rx_mac_interface_pkg;

    // Receive FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_DROP = 2'd2
    } rx_state_t;

    // Header qword layout: byte count in the upper half, lower half zero
    localparam int HDR_BYTES_MSB  = 63;
    localparam int HDR_BYTES_LSB  = 32;

    // Default buffer address width (512 qwords)
    localparam int DEFAULT_ADDR_W = 9;

endpackage
`default_nettype wire

// File: rtl/byte_mask_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : byte_mask_popcount
//  Description : Converts an 8-bit contiguous byte-valid mask into the number
//                of valid bytes (0..8). Shared with the TX valid-mask decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_mask_popcount (
    input  logic [7:0] i_mask,
    output logic [3:0] o_count
);

    // Sum of set mask bits
    always_comb begin
        o_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            o_count = o_count + {3'b000, i_mask[i]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/rx_mac_interface.sv
`default_nettype none
// ============================================================================
//  Module      : rx_mac_interface
//  Description : Writes frames from the 10G MAC receive client into the frame
//                buffer as {header, payload...}. A frame becomes visible to
//                the reader only after good status; bad or overflowing frames
//                are rolled back. Optional statistics counters are enabled by
//                defining RX_MAC_INSTRUMENTATION_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_mac_interface
    import rx_mac_interface_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       rx_data,
    input  logic [7:0]        rx_data_valid,
    input  logic              rx_good_frame,
    input  logic              rx_bad_frame,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data,
    output logic              wr_en,
    output logic [ADDR_W:0]   commited_wr_addr,
    input  logic [ADDR_W:0]   commited_rd_addr,
    output logic              rx_overflow
`ifdef RX_MAC_INSTRUMENTATION_EN
    ,
    output logic [31:0]       frames_received,
    output logic [31:0]       frames_dropped
`endif
);

    localparam logic [ADDR_W:0] c_PTR_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] c_PTR_TWO  = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0] c_DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_DEPTH_M1 = {1'b0, {ADDR_W{1'b1}}};

    rx_state_t         r_state, w_state_nxt;
    logic [ADDR_W:0]   r_wr_ptr, w_wr_ptr_nxt;
    logic [ADDR_W:0]   r_sof_ptr, w_sof_ptr_nxt;
    logic [ADDR_W:0]   r_commit_ptr, w_commit_ptr_nxt;
    logic              r_commit_pend, w_commit_pend_nxt;
    logic [31:0]       r_byte_cnt, w_byte_cnt_nxt;
    logic [ADDR_W-1:0] w_wr_addr_nxt;
    logic [63:0]       w_wr_data_nxt;
    logic              w_wr_en_nxt;
    logic              w_overflow_nxt;

    logic [ADDR_W:0]   w_used;
    logic [ADDR_W:0]   w_first_ptr;
    logic [3:0]        w_pop;
    logic              w_beat;
    logic              w_status;
    logic              w_good_commit;

    byte_mask_popcount u_popcount (
        .i_mask  (rx_data_valid),
        .o_count (w_pop)
    );

    // Occupancy includes the uncommitted frame in flight (header slot too)
    assign w_used        = r_wr_ptr - commited_rd_addr;
    assign w_first_ptr   = r_wr_ptr + c_PTR_ONE;
    assign w_beat        = |rx_data_valid;
    assign w_status      = rx_good_frame | rx_bad_frame;
    // Good only when unambiguous: no bad strobe and no data in the same beat
    assign w_good_commit = rx_good_frame & ~rx_bad_frame & ~w_beat;

    // Next-state and buffer-write decode
    always_comb begin
        w_state_nxt       = r_state;
        w_wr_ptr_nxt      = r_wr_ptr;
        w_sof_ptr_nxt     = r_sof_ptr;
        w_byte_cnt_nxt    = r_byte_cnt;
        w_commit_ptr_nxt  = r_commit_ptr;
        w_commit_pend_nxt = 1'b0;
        w_wr_en_nxt       = 1'b0;
        w_wr_addr_nxt     = wr_addr;
        w_wr_data_nxt     = wr_data;
        w_overflow_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A beat carrying status is a malformed one-beat frame: dropped
                if (w_beat && !w_status) begin
                    if (w_used >= c_DEPTH_M1) begin
                        w_overflow_nxt = 1'b1;
                        w_state_nxt    = S_DROP;
                    end else begin
                        // Leave the slot at wr_ptr free for the header
                        w_sof_ptr_nxt  = r_wr_ptr;
                        w_wr_addr_nxt  = w_first_ptr[ADDR_W-1:0];
                        w_wr_data_nxt  = rx_data;
                        w_wr_en_nxt    = 1'b1;
                        w_wr_ptr_nxt   = r_wr_ptr + c_PTR_TWO;
                        w_byte_cnt_nxt = {28'd0, w_pop};
                        w_state_nxt    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_status) begin
                    if (w_good_commit) begin
                        w_wr_addr_nxt = r_sof_ptr[ADDR_W-1:0];
                        w_wr_data_nxt = 64'd0;
                        w_wr_data_nxt[HDR_BYTES_MSB:HDR_BYTES_LSB] = r_byte_cnt;
                        w_wr_en_nxt       = 1'b1;
                        // Publish one cycle after the header lands
                        w_commit_ptr_nxt  = r_wr_ptr;
                        w_commit_pend_nxt = 1'b1;
                    end else begin
                        w_wr_ptr_nxt = r_sof_ptr;
                    end
                    w_state_nxt = S_IDLE;
                end else if (w_beat) begin
                    if (w_used == c_DEPTH) begin
                        w_wr_ptr_nxt   = r_sof_ptr;
                        w_overflow_nxt = 1'b1;
                        w_state_nxt    = S_DROP;
                    end else begin
                        w_wr_addr_nxt  = r_wr_ptr[ADDR_W-1:0];
                        w_wr_data_nxt  = rx_data;
                        w_wr_en_nxt    = 1'b1;
                        w_wr_ptr_nxt   = w_first_ptr;
                        w_byte_cnt_nxt = r_byte_cnt + {28'd0, w_pop};
                    end
                end
            end
            S_DROP: begin
                if (w_status) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointers, byte count and registered buffer/commit outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr         <= '0;
            r_sof_ptr        <= '0;
            r_commit_ptr     <= '0;
            r_commit_pend    <= 1'b0;
            r_byte_cnt       <= 32'd0;
            wr_addr          <= '0;
            wr_data          <= 64'd0;
            wr_en            <= 1'b0;
            commited_wr_addr <= '0;
            rx_overflow      <= 1'b0;
        end else begin
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_sof_ptr     <= w_sof_ptr_nxt;
            r_commit_ptr  <= w_commit_ptr_nxt;
            r_commit_pend <= w_commit_pend_nxt;
            r_byte_cnt    <= w_byte_cnt_nxt;
            wr_addr       <= w_wr_addr_nxt;
            wr_data       <= w_wr_data_nxt;
            wr_en         <= w_wr_en_nxt;
            rx_overflow   <= w_overflow_nxt;
            if (r_commit_pend) begin
                commited_wr_addr <= r_commit_ptr;
            end
        end
    end

`ifdef RX_MAC_INSTRUMENTATION_EN
    logic w_drop_evt;
    assign w_drop_evt = w_overflow_nxt |
                        ((r_state == S_DATA) & w_status & ~w_good_commit);

    // Statistics: frames published and frames discarded
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frames_received <= 32'd0;
            frames_dropped  <= 32'd0;
        end else begin
            if (r_commit_pend) begin
                frames_received <= frames_received + 32'd1;
            end
            if (w_drop_evt) begin
                frames_dropped <= frames_dropped + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
